// File: rtl/isp_ee_ctrl_pkg.sv
// Shared definitions for the EE frame controller: register map, bit positions, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package isp_ee_ctrl_pkg;

    // Register word addresses
    localparam logic [1:0] ADDR_CTRL      = 2'd0;
    localparam logic [1:0] ADDR_STATUS    = 2'd1;
    localparam logic [1:0] ADDR_FRAME_CNT = 2'd2;
    localparam logic [1:0] ADDR_LAST_SIZE = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EE_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    // STATUS bit positions
    localparam int STAT_FRAME_DONE = 0;
    localparam int STAT_SIZE_ERR   = 1;
    localparam int STAT_BUSY       = 2;

    // Frame FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Geometry counters stick at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/isp_ee_bypass_dly.sv
// Bypass delay line: carries href/vsync/YUV through EE_DLY register stages to match the EE datapath.
// Latency: exactly EE_DLY pclk cycles from src_* to dly_*.
// Backpressure: none; shifts every cycle.
module isp_ee_bypass_dly #(
    parameter int BITS   = 8,
    parameter int EE_DLY = 6
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            src_href,
    input  logic            src_vsync,
    input  logic [BITS-1:0] src_y,
    input  logic [BITS-1:0] src_u,
    input  logic [BITS-1:0] src_v,
    output logic            dly_href,
    output logic            dly_vsync,
    output logic [BITS-1:0] dly_y,
    output logic [BITS-1:0] dly_u,
    output logic [BITS-1:0] dly_v
);

    localparam int W = 2 + 3 * BITS;

    logic [W-1:0] pipe [EE_DLY];

    // Shift the packed sync+pixel word one stage per cycle; reset flushes the whole line
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < EE_DLY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {src_href, src_vsync, src_y, src_u, src_v};
            for (int i = 1; i < EE_DLY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign {dly_href, dly_vsync, dly_y, dly_u, dly_v} = pipe[EE_DLY-1];

endmodule

// File: rtl/isp_ee_ctrl.sv
// EE frame controller: register port, frame-boundary config shadowing, EE/bypass output mux, geometry check.
// Latency: out_* trail in_* by EE_DLY pclk cycles on either path; cfg_rdata one cycle after cfg_rd.
// Backpressure: none; the pixel stream is free-running and accepted every cycle.
module isp_ee_ctrl
    import isp_ee_ctrl_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960,
    parameter int EE_DLY = 6
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            cfg_wr,
    input  logic            cfg_rd,
    input  logic [1:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    output logic [31:0]     cfg_rdata,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_y,
    input  logic [BITS-1:0] in_u,
    input  logic [BITS-1:0] in_v,
    input  logic            ee_out_href,
    input  logic            ee_out_vsync,
    input  logic [BITS-1:0] ee_out_y,
    input  logic [BITS-1:0] ee_out_u,
    input  logic [BITS-1:0] ee_out_v,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_y,
    output logic [BITS-1:0] out_u,
    output logic [BITS-1:0] out_v,
    output logic            irq
);

    localparam logic [15:0] WIDTH16  = 16'(WIDTH);
    localparam logic [15:0] HEIGHT16 = 16'(HEIGHT);

    // Register state
    logic        ctrl_ee_en;
    logic        ctrl_irq_en;
    logic        frame_done;
    logic        size_err;
    logic [15:0] frame_cnt;
    logic [15:0] last_lines;
    logic [15:0] last_pix;

    // Frame tracking
    logic [1:0]  state;
    logic [15:0] line_cnt;
    logic [15:0] pix_cnt;
    logic [15:0] line_inc;
    logic        href_q;
    logic        vsync_q;
    logic        vs_rise;
    logic        hr_rise;
    logic        hr_fall;
    logic        set_done;
    logic        set_err;
    logic        busy;

    // Shadowing and output select
    logic        ee_en_sh;
    logic        out_sel;
    logic        dly_vs_q;
    logic        dly_vs_rise;
    logic        sel_now;
    logic        sel_href;

    // Bypass path
    logic            byp_href;
    logic            byp_vsync;
    logic [BITS-1:0] byp_y;
    logic [BITS-1:0] byp_u;
    logic [BITS-1:0] byp_v;

    logic        w1c_hit;
    logic        wdata_unused;

    assign wdata_unused = ^cfg_wdata[31:2];

    assign vs_rise     = in_vsync & ~vsync_q;
    assign hr_rise     = in_href & ~href_q;
    assign hr_fall     = ~in_href & href_q;
    assign busy        = (state != ST_IDLE);
    assign w1c_hit     = cfg_wr && (cfg_addr == ADDR_STATUS);
    assign dly_vs_rise = byp_vsync & ~dly_vs_q;
    // The select switches in the very cycle the delayed vsync rises, so a whole output frame uses one path
    assign sel_now     = dly_vs_rise ? ee_en_sh : out_sel;
    assign irq         = ctrl_irq_en & (frame_done | size_err);

    isp_ee_bypass_dly #(
        .BITS   (BITS),
        .EE_DLY (EE_DLY)
    ) u_bypass (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .src_href  (in_href),
        .src_vsync (in_vsync),
        .src_y     (in_y),
        .src_u     (in_u),
        .src_v     (in_v),
        .dly_href  (byp_href),
        .dly_vsync (byp_vsync),
        .dly_y     (byp_y),
        .dly_u     (byp_u),
        .dly_v     (byp_v)
    );

    // Registered copies of the input syncs for edge detection
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            href_q  <= in_href;
            vsync_q <= in_vsync;
        end
    end

    // Geometry events raised by the current sync edges
    always_comb begin
        set_done = 1'b0;
        set_err  = 1'b0;
        line_inc = sat_inc16(line_cnt);
        case (state)
            ST_ACTIVE: begin
                if (vs_rise) begin
                    set_err = 1'b1;
                end else if (hr_fall) begin
                    set_err  = (pix_cnt != WIDTH16);
                    set_done = (line_inc == HEIGHT16);
                end
            end
            ST_DONE: begin
                set_err = hr_rise & ~vs_rise;
            end
            default: ;
        endcase
    end

    // Frame FSM with line/pixel counters and last-line geometry capture
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            line_cnt   <= '0;
            pix_cnt    <= '0;
            last_lines <= '0;
            last_pix   <= '0;
            frame_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (vs_rise) begin
                        state    <= ST_ACTIVE;
                        line_cnt <= '0;
                        pix_cnt  <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (vs_rise) begin
                        line_cnt <= '0;
                        pix_cnt  <= '0;
                    end else if (hr_fall) begin
                        line_cnt   <= line_inc;
                        last_lines <= line_inc;
                        last_pix   <= pix_cnt;
                        pix_cnt    <= '0;
                        if (set_done) begin
                            state     <= ST_DONE;
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end else if (in_href) begin
                        pix_cnt <= sat_inc16(pix_cnt);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // CTRL writes and sticky STATUS flags; a set event beats a same-cycle W1C
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_ee_en  <= 1'b0;
            ctrl_irq_en <= 1'b0;
            frame_done  <= 1'b0;
            size_err    <= 1'b0;
        end else begin
            if (cfg_wr && (cfg_addr == ADDR_CTRL)) begin
                ctrl_ee_en  <= cfg_wdata[CTRL_EE_EN];
                ctrl_irq_en <= cfg_wdata[CTRL_IRQ_EN];
            end
            frame_done <= set_done | (frame_done & ~(w1c_hit & cfg_wdata[STAT_FRAME_DONE]));
            size_err   <= set_err  | (size_err   & ~(w1c_hit & cfg_wdata[STAT_SIZE_ERR]));
        end
    end

    // ee_en shadows at the input frame start; out_sel follows at the delayed frame start
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            ee_en_sh <= 1'b0;
            out_sel  <= 1'b0;
            dly_vs_q <= 1'b0;
        end else begin
            dly_vs_q <= byp_vsync;
            if (vs_rise) begin
                ee_en_sh <= ctrl_ee_en;
            end
            if (dly_vs_rise) begin
                out_sel <= ee_en_sh;
            end
        end
    end

    // Output mux; pixel data forced to zero outside the selected href
    always_comb begin
        sel_href  = sel_now ? ee_out_href : byp_href;
        out_href  = sel_href;
        out_vsync = sel_now ? ee_out_vsync : byp_vsync;
        out_y     = '0;
        out_u     = '0;
        out_v     = '0;
        if (sel_href) begin
            out_y = sel_now ? ee_out_y : byp_y;
            out_u = sel_now ? ee_out_u : byp_u;
            out_v = sel_now ? ee_out_v : byp_v;
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_rdata <= '0;
        end else if (cfg_rd) begin
            case (cfg_addr)
                ADDR_CTRL:      cfg_rdata <= {30'd0, ctrl_irq_en, ctrl_ee_en};
                ADDR_STATUS:    cfg_rdata <= {29'd0, busy, size_err, frame_done};
                ADDR_FRAME_CNT: cfg_rdata <= {16'd0, frame_cnt};
                default:        cfg_rdata <= {last_lines, last_pix};
            endcase
        end
    end

endmodule

// File: tb/tb_isp_ee_ctrl.sv
// Randomized-pixel bench for isp_ee_ctrl with a frame/line-level reference model and scoreboard.
// Latency: expected pixels and vsync edges are stamped with issue cycle + EE_DLY.
// Backpressure: none; the monitor samples every falling pclk edge.
module tb_isp_ee_ctrl;

    localparam int BITS   = 8;
    localparam int WIDTH  = 8;
    localparam int HEIGHT = 4;
    localparam int EE_DLY = 6;
    localparam int PW     = 3 * BITS;

    logic            pclk;
    logic            rst_n;
    logic            cfg_wr, cfg_rd;
    logic [1:0]      cfg_addr;
    logic [31:0]     cfg_wdata;
    logic [31:0]     cfg_rdata;
    logic            in_href, in_vsync;
    logic [BITS-1:0] in_y, in_u, in_v;
    logic            ee_out_href, ee_out_vsync;
    logic [BITS-1:0] ee_out_y, ee_out_u, ee_out_v;
    logic            out_href, out_vsync;
    logic [BITS-1:0] out_y, out_u, out_v;
    logic            irq;

    isp_ee_ctrl #(
        .BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .EE_DLY(EE_DLY)
    ) dut (
        .pclk(pclk), .rst_n(rst_n),
        .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .in_href(in_href), .in_vsync(in_vsync), .in_y(in_y), .in_u(in_u), .in_v(in_v),
        .ee_out_href(ee_out_href), .ee_out_vsync(ee_out_vsync),
        .ee_out_y(ee_out_y), .ee_out_u(ee_out_u), .ee_out_v(ee_out_v),
        .out_href(out_href), .out_vsync(out_vsync),
        .out_y(out_y), .out_u(out_u), .out_v(out_v),
        .irq(irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // Stand-in for the EE datapath: fixed per-component transform, EE_DLY cycles late
    logic [2+PW-1:0] ee_pipe [EE_DLY];
    always @(posedge pclk) begin
        if (!rst_n) begin
            for (int i = 0; i < EE_DLY; i++) ee_pipe[i] <= '0;
        end else begin
            ee_pipe[0] <= {in_href, in_vsync, ~in_y, in_u + 8'd1, in_v ^ 8'h3C};
            for (int i = 1; i < EE_DLY; i++) ee_pipe[i] <= ee_pipe[i-1];
        end
    end
    assign {ee_out_href, ee_out_vsync, ee_out_y, ee_out_u, ee_out_v} = ee_pipe[EE_DLY-1];

    // Scoreboard queues
    typedef struct { int cyc; logic [PW-1:0] dat; } pix_t;
    typedef struct { int cyc; logic [31:0] dat; logic irq; } rd_t;
    pix_t pix_q[$];
    int   vs_q[$];
    rd_t  rd_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model, kept at register/line/frame granularity
    logic        m_ee_en, m_irq_en, m_fd, m_se;
    int          m_state;            // 0 idle, 1 in frame, 2 frame complete
    logic [15:0] m_lines, m_frames, m_last_lines, m_last_pix;
    logic        frame_sel;
    logic        prev_vs;

    task automatic model_clear();
        m_ee_en = 0; m_irq_en = 0; m_fd = 0; m_se = 0; m_state = 0;
        m_lines = 0; m_frames = 0; m_last_lines = 0; m_last_pix = 0;
        frame_sel = 0; prev_vs = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_irq_en, m_ee_en};
            2'd1:    return {29'd0, (m_state != 0), m_se, m_fd};
            2'd2:    return {16'd0, m_frames};
            default: return {m_last_lines, m_last_pix};
        endcase
    endfunction

    task automatic model_write(input logic [1:0] a, input logic [31:0] d);
        if (a == 2'd0) begin
            m_ee_en  = d[0];
            m_irq_en = d[1];
        end else if (a == 2'd1) begin
            if (d[0]) m_fd = 0;
            if (d[1]) m_se = 0;
        end
    endtask

    task automatic model_line(input int n);
        if (m_state == 1) begin
            if (m_lines != 16'hFFFF) m_lines = m_lines + 16'd1;
            m_last_lines = m_lines;
            m_last_pix   = 16'(n);
            if (n != WIDTH) m_se = 1;
            if (m_lines == 16'(HEIGHT)) begin
                m_state  = 2;
                m_fd     = 1;
                m_frames = m_frames + 16'd1;
            end
        end else if (m_state == 2) begin
            m_se = 1;
        end
    endtask

    task automatic model_frame_start();
        if (m_state == 1) m_se = 1;
        m_state = 1;
        m_lines = 0;
    endtask

    // Stimulus primitives
    logic        nxt_wr, nxt_rd;
    logic [1:0]  nxt_addr;
    logic [31:0] nxt_wdata;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic cycle(input logic hr, input logic vs);
        logic [BITS-1:0] y, u, v;
        rd_t r;
        pix_t p;
        y = 8'($urandom); u = 8'($urandom); v = 8'($urandom);
        in_href = hr; in_vsync = vs; in_y = y; in_u = u; in_v = v;
        cfg_wr = nxt_wr; cfg_rd = nxt_rd; cfg_addr = nxt_addr; cfg_wdata = nxt_wdata;
        if (nxt_rd) begin
            r.cyc = cyc + 1;
            r.dat = model_read(nxt_addr);
            r.irq = m_irq_en & (m_fd | m_se);
            rd_q.push_back(r);
        end
        if (vs && !prev_vs) begin
            frame_sel = m_ee_en;
            vs_q.push_back(cyc + EE_DLY);
        end
        if (nxt_wr) model_write(nxt_addr, nxt_wdata);
        if (hr) begin
            p.cyc = cyc + EE_DLY;
            p.dat = frame_sel ? {~y, 8'(u + 8'd1), v ^ 8'h3C} : {y, u, v};
            pix_q.push_back(p);
        end
        prev_vs = vs;
        nxt_wr = 0; nxt_rd = 0;
        tick();
        cfg_wr = 0; cfg_rd = 0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        nxt_wr = 1; nxt_addr = a; nxt_wdata = d;
        cycle(0, 0);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        nxt_rd = 1; nxt_addr = a;
        cycle(0, 0);
    endtask

    // n active pixels then two blank cycles; optional register write on cycle index wr_at
    task automatic send_line(input int n, input int wr_at, input logic [1:0] wa, input logic [31:0] wd);
        for (int i = 0; i < n + 2; i++) begin
            if (i == wr_at) begin
                nxt_wr = 1; nxt_addr = wa; nxt_wdata = wd;
            end
            cycle(i < n, 0);
        end
        model_line(n);
    endtask

    task automatic vsync_pulse();
        cycle(0, 1); cycle(0, 1); cycle(0, 0); cycle(0, 0);
        model_frame_start();
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        in_href = 0; in_vsync = 0; in_y = 0; in_u = 0; in_v = 0;
        cfg_wr = 0; cfg_rd = 0; cfg_addr = 0; cfg_wdata = 0;
        nxt_wr = 0; nxt_rd = 0; nxt_addr = 0; nxt_wdata = 0;
        pix_q.delete(); vs_q.delete(); rd_q.delete();
        model_clear();
        #1;
        chk("rst_out_sync", {30'd0, out_href, out_vsync}, 32'd0);
        chk("rst_out_dat", {8'd0, out_y, out_u, out_v}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdata", cfg_rdata, 32'd0);
        repeat (n) tick();
        rst_n = 1;
        tick();
    endtask

    // Monitor: pops expectations whenever the DUT presents pixels, vsync edges or read data
    logic prev_ovs = 0;
    always @(negedge pclk) begin
        pix_t e;
        rd_t  r;
        int   v;
        if (!rst_n) begin
            chk("reset_out_zero", {6'd0, out_href, out_vsync, out_y, out_u, out_v}, 32'd0);
        end else begin
            if (out_href) begin
                if (pix_q.size() == 0) begin
                    chk("pix_unexpected", {31'd0, out_href}, 32'd0);
                end else begin
                    e = pix_q.pop_front();
                    chk("pix_cycle", 32'(cyc), 32'(e.cyc));
                    chk("pix_data", {8'd0, out_y, out_u, out_v}, {8'd0, e.dat});
                end
            end else begin
                chk("blank_data_zero", {8'd0, out_y, out_u, out_v}, 32'd0);
            end
            if (out_vsync && !prev_ovs) begin
                if (vs_q.size() == 0) begin
                    chk("vsync_unexpected", {31'd0, out_vsync}, 32'd0);
                end else begin
                    v = vs_q.pop_front();
                    chk("vsync_cycle", 32'(cyc), 32'(v));
                end
            end
            if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
                r = rd_q.pop_front();
                chk("rdata", cfg_rdata, r.dat);
                chk("irq", {31'd0, irq}, {31'd0, r.irq});
            end
        end
        prev_ovs = out_vsync;
    end

    initial begin
        rst_n = 1;
        in_href = 0; in_vsync = 0; in_y = 0; in_u = 0; in_v = 0;
        cfg_wr = 0; cfg_rd = 0; cfg_addr = 0; cfg_wdata = 0;
        #1;
        do_reset(4);

        // Reset values and CTRL read-back
        for (int a = 0; a < 4; a++) rd_reg(2'(a));
        wr_reg(2'd0, 32'h3); rd_reg(2'd0);
        wr_reg(2'd0, 32'h0); rd_reg(2'd1);

        // Good frame, bypass, irq disabled
        vsync_pulse();
        repeat (HEIGHT) send_line(WIDTH, -1, 2'd0, 32'd0);
        rd_reg(2'd1); rd_reg(2'd2); rd_reg(2'd3);
        wr_reg(2'd0, 32'h2); rd_reg(2'd1);
        wr_reg(2'd1, 32'h3); rd_reg(2'd1);

        // Enable EE mid-frame: this frame stays bypass, next frame switches
        vsync_pulse();
        send_line(WIDTH, -1, 2'd0, 32'd0);
        send_line(WIDTH, 3, 2'd0, 32'h3);
        send_line(WIDTH, -1, 2'd0, 32'd0);
        send_line(WIDTH, -1, 2'd0, 32'd0);
        vsync_pulse();
        repeat (HEIGHT) send_line(WIDTH, -1, 2'd0, 32'd0);
        rd_reg(2'd2); rd_reg(2'd1);

        // Short line
        wr_reg(2'd0, 32'h2); wr_reg(2'd1, 32'h3);
        vsync_pulse();
        send_line(WIDTH, -1, 2'd0, 32'd0);
        send_line(WIDTH - 1, -1, 2'd0, 32'd0);
        send_line(WIDTH, -1, 2'd0, 32'd0);
        send_line(WIDTH, -1, 2'd0, 32'd0);
        rd_reg(2'd1); rd_reg(2'd3); rd_reg(2'd2);

        // Short frame, then a complete one, then an extra line after completion
        wr_reg(2'd1, 32'h3);
        vsync_pulse();
        repeat (HEIGHT - 1) send_line(WIDTH, -1, 2'd0, 32'd0);
        vsync_pulse();
        rd_reg(2'd1); rd_reg(2'd2);
        wr_reg(2'd1, 32'h3);
        repeat (HEIGHT) send_line(WIDTH, -1, 2'd0, 32'd0);
        rd_reg(2'd1); rd_reg(2'd2);
        wr_reg(2'd1, 32'h3);
        send_line(WIDTH, -1, 2'd0, 32'd0);
        rd_reg(2'd1);

        // W1C of frame_done on the cycle frame_done is set
        wr_reg(2'd1, 32'h3);
        vsync_pulse();
        repeat (HEIGHT - 1) send_line(WIDTH, -1, 2'd0, 32'd0);
        send_line(WIDTH, WIDTH, 2'd1, 32'h1);
        rd_reg(2'd1); rd_reg(2'd2);
        wr_reg(2'd1, 32'h3);
        chk("irq_drop_after_w1c", {31'd0, irq}, 32'd0);
        rd_reg(2'd1);

        // Reset in the middle of line 2 of an EE frame
        wr_reg(2'd0, 32'h3);
        vsync_pulse();
        send_line(WIDTH, -1, 2'd0, 32'd0);
        cycle(1, 0); cycle(1, 0); cycle(1, 0);
        do_reset(3);
        send_line(WIDTH, -1, 2'd0, 32'd0);
        send_line(WIDTH, -1, 2'd0, 32'd0);
        for (int a = 0; a < 4; a++) rd_reg(2'(a));

        // Drain and confirm nothing expected was left unseen
        repeat (EE_DLY + 6) cycle(0, 0);
        chk("pix_queue_drained", 32'(pix_q.size()), 32'd0);
        chk("vsync_queue_drained", 32'(vs_q.size()), 32'd0);
        chk("read_queue_drained", 32'(rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/isp_ee_ctrl.md
# isp_ee_ctrl

Frame-level controller for the ISP edge-enhancement stage. It holds the EE register set behind a small register port and latches configuration only at frame boundaries. It selects between the EE datapath output and a latency-matched bypass path, checks incoming frame geometry against WIDTH×HEIGHT, and raises frame-done and size-error events. It sits between the register bus bridge and the EE instance in the ISP pipeline.

## Interface
- BITS, 8, pixel component width
- WIDTH, 1280, expected pixels per line
- HEIGHT, 960, expected lines per frame
- EE_DLY, 6, EE datapath latency in pclk cycles
- pclk  in  1  pixel clock, single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- cfg_wr  in  1  register write strobe
- cfg_rd  in  1  register read strobe
- cfg_addr  in  2  register word address
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data, registered
- in_href, in_vsync  in  1 each  incoming sync
- in_y, in_u, in_v  in  BITS each  incoming YUV
- ee_out_href, ee_out_vsync, ee_out_y, ee_out_u, ee_out_v  in  1/1/BITS×3  EE datapath result; the EE input is wired directly from in_*
- out_href, out_vsync  out  1 each  muxed output sync
- out_y, out_u, out_v  out  BITS each  muxed output data
- irq  out  1  level interrupt

## Operation
- Registers:
  - 0 CTRL (RW): bit0 ee_en, bit1 irq_en; reset 0.
  - 1 STATUS: bit0 frame_done (sticky, W1C), bit1 size_err (sticky, W1C), bit2 busy (RO, state≠IDLE).
  - 2 FRAME_CNT (RO): [15:0] completed frames, wraps 0xFFFF→0.
  - 3 LAST_SIZE (RO): [31:16] line count, [15:0] pixel count of the last finished line.
  - Unmapped bits read 0.
- Shadowing:
  - ee_en_sh loads CTRL.ee_en on every in_vsync rising edge.
  - out_sel loads ee_en_sh on the rising edge of the EE_DLY-delayed vsync, so the mux switches only between frames at the output side.
  - Writes mid-frame never affect the current frame.
- Bypass: in_href/in_vsync/in_y/u/v delayed EE_DLY cycles. out_* = out_sel ? ee_out_* : bypass_*. Data outputs are 0 when the selected href is 0.
- FSM (in_* edges detected against 1-cycle registered copies):
  - IDLE: on vsync rise → ACTIVE; clear line_cnt and pix_cnt.
  - ACTIVE:
    - pix_cnt counts cycles with href=1.
    - On href fall: line_cnt+1; LAST_SIZE updated; pix_cnt≠WIDTH → size_err; pix_cnt cleared.
    - When line_cnt reaches HEIGHT → DONE; frame_done set; FRAME_CNT+1.
    - On vsync rise (short frame): size_err set; restart ACTIVE with counters cleared.
  - DONE: href rise → size_err (extra line), stay DONE. vsync rise → ACTIVE with counters cleared.
- Counters are 16 bits and saturate at 0xFFFF.
- Simultaneous W1C and set event in the same cycle: set wins.
- irq = irq_en & (frame_done | size_err).

## Timing
- Reset values:
  - cfg_rdata 0, irq 0, out_* 0.
  - All registers, shadows, counters and delay line 0.
  - FSM in IDLE.
- cfg_rdata valid the cycle after cfg_rd; it holds its value until the next read.
- Write takes effect the cycle after cfg_wr. W1C on STATUS takes effect the same edge as the write.
- Status/irq update one cycle after the triggering in_* edge.
- Output latency in both paths: exactly EE_DLY cycles from in_* to out_*.
- Reset asserted mid-frame: everything returns to reset values immediately; the first frame after release begins at the next vsync rise.

## Structure
- Package isp_ee_ctrl_pkg:
  - register address constants and STATUS/CTRL bit positions
  - FSM state encoding {IDLE, ACTIVE, DONE}
- Sub-module isp_ee_bypass_dly, parameterised by BITS and EE_DLY: the sync-plus-YUV delay line. It carries the async reset, like every other register in the block.

## Test plan
Parameters for all scenarios: WIDTH=8, HEIGHT=4, EE_DLY=6.
- Reset/regs: after reset, read all 4 addresses → 0. Write CTRL=0x3 → reads 0x3 next read. STATUS busy=0.
- Good frame, ee_en=0: vsync pulse then 4 lines of 8 pixels → out_* equals in_* delayed exactly 6 cycles. frame_done=1, FRAME_CNT=1, LAST_SIZE=0x0004_0008, irq=1 only if irq_en=1.
- Mid-frame enable: write ee_en=1 during line 2 → the frame still outputs bypass data. The next frame outputs ee_out_* from its first delayed-vsync edge onward.
- Geometry errors: a line of 7 pixels → size_err=1. Separately, 3 lines then vsync → size_err=1 and FRAME_CNT unchanged. A 5th line after DONE → size_err=1.
- W1C race: write STATUS=0x1 on the same cycle frame_done is set → frame_done remains 1. Write 0x3 with no event → both clear and irq drops next cycle.
- Reset mid-frame: assert rst_n low during line 2 → out_* 0 and FSM IDLE. After release, lines without a vsync rise → no counting, busy=0.
